// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks (convolver, pooling, later stages).
package cnn_pkg;

  // Default data width for feature-map samples.
  localparam int DW_DEFAULT = 32;

  // Widest sample the max helper handles. Narrower callers sign-extend into it
  // and truncate the result back.
  localparam int SMAX_W = 64;

  // Signed maximum. A tie returns a, which is equal to b anyway.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

  // Output size of a valid (unpadded) convolution: (n-k)/s + 1.
  function automatic int fm_size(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer for the pooling stage. It holds one horizontal partial maximum per
// window column of the current window row. It has one write port and one
// combinational read port.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = 1
) (
  input  logic                 clk,
  input  logic                 global_rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  // The array spans the full address range, so no select can fall outside it.
  // Only the low DEPTH entries are ever addressed.
  localparam int ENTRIES = 1 << AW;

  logic signed [DW-1:0] mem_q [ENTRIES];

  // Write port. A reset clears every entry.
  // NOTE: this storage is a small register array, not a RAM macro, so it can
  // take a reset. A reset makes a mid-frame restart fully deterministic.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read, addressed by col/2 of the pixel being accepted.
  assign rdata = mem_q[raddr];

  // Ties DEPTH to the instance for readability. It has no effect on logic.
  localparam int UNUSED_DEPTH_CHECK = DEPTH;

endmodule

// File: rtl/max_pool_stage.sv
// Streaming 2x2 / stride-2 max-pooling stage with an optional ReLU.
// It consumes the raster-ordered convolver stream. It emits one value per
// window, plus an end-of-frame strobe and a framing-error strobe.
module max_pool_stage
  import cnn_pkg::*;
#(
  parameter int M    = 2,           // conv map width = height, even and >= 2
  parameter int DW   = DW_DEFAULT,  // sample width, signed, <= SMAX_W
  parameter int RELU = 1            // 1: clamp negative results to 0
) (
  input  logic                 clk,
  input  logic                 global_rst,
  input  logic                 ce,
  input  logic signed [DW-1:0] conv_op,
  input  logic                 valid_conv,
  input  logic                 end_conv,
  output logic signed [DW-1:0] pool_op,
  output logic                 valid_pool,
  output logic                 end_pool,
  output logic                 frame_err
);

  localparam int CW   = $clog2(M);
  localparam int HALF = M / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  // Position counters and the even-column sample of the current window row.
  logic [CW-1:0]        col_q, col_d;
  logic [CW-1:0]        row_q, row_d;
  logic signed [DW-1:0] hmax_q, hmax_d;

  // Output registers.
  logic signed [DW-1:0] pool_q, pool_d;
  logic                 valid_q, valid_d;
  logic                 end_q, end_d;
  logic                 err_q, err_d;

  // Datapath nets.
  logic                 accept;
  logic                 col_last, row_last, at_last;
  logic signed [DW-1:0] h, pooled, pooled_act;
  logic signed [DW-1:0] lb_rdata;
  logic [AW-1:0]        lb_idx;
  logic                 lb_we;

  assign accept   = ce & valid_conv;
  assign col_last = (col_q == CW'(M - 1));
  assign row_last = (row_q == CW'(M - 1));
  assign at_last  = col_last & row_last;
  assign lb_idx   = AW'(col_q >> 1);

  // Horizontal max of the pixel pair, then vertical max against the stored top row.
  assign h          = DW'(smax(SMAX_W'(hmax_q), SMAX_W'(conv_op)));
  assign pooled     = DW'(smax(SMAX_W'(lb_rdata), SMAX_W'(h)));
  assign pooled_act = (RELU != 0 && pooled[DW-1]) ? '0 : pooled;

  pool_line_buffer #(
    .DEPTH (HALF),
    .DW    (DW),
    .AW    (AW)
  ) u_line_buffer (
    .clk        (clk),
    .global_rst (global_rst),
    .we         (lb_we),
    .waddr      (lb_idx),
    .wdata      (h),
    .raddr      (lb_idx),
    .rdata      (lb_rdata)
  );

  // Next-state logic: counters, horizontal max, line-buffer write and output strobes.
  // NOTE: every signal gets a default before any branch. A branch that leaves
  // a signal unassigned would otherwise infer a latch.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hmax_d  = hmax_q;
    pool_d  = pool_q;
    valid_d = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    lb_we   = 1'b0;

    if (accept) begin
      if (end_conv && !at_last) begin
        // The frame ended early. Drop this pixel and restart at (0,0). Every
        // line-buffer entry is rewritten before it is next read.
        err_d  = 1'b1;
        col_d  = '0;
        row_d  = '0;
        hmax_d = '0;
      end else begin
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end

        if (!col_q[0]) begin
          hmax_d = conv_op;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          pool_d  = pooled_act;
          valid_d = 1'b1;
          end_d   = end_conv;  // only reachable with end_conv at (M-1, M-1)
        end
      end
    end
  end

  // State registers. A synchronous reset takes priority over ce.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hmax_q  <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hmax_q  <= hmax_d;
      pool_q  <= pool_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign pool_op    = pool_q;
  assign valid_pool = valid_q;
  assign end_pool   = end_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_max_pool_stage.sv
// Directed bench for max_pool_stage. Two M=4 instances (RELU on and off) share
// one stream. An M=2 instance is fed a convolver-sized stream that has gaps and
// a ce stall.
module tb_max_pool_stage;
  import cnn_pkg::*;

  typedef int quad_t [4];

  localparam int MC = fm_size(6, 5, 1);  // = 2

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  logic signed [31:0] conv_ab = '0;
  logic               valid_ab = 1'b0, end_ab = 1'b0;
  logic signed [31:0] pool_a, pool_b;
  logic               vp_a, ep_a, er_a, vp_b, ep_b, er_b;

  logic signed [31:0] conv_c = '0;
  logic               valid_c = 1'b0, end_c = 1'b0;
  logic signed [31:0] pool_c;
  logic               vp_c, ep_c, er_c;

  int n_cmp = 0;
  int n_bad = 0;

  int                 cnt_c = 0;
  logic signed [31:0] last_c = '0;
  logic               end_seen_c = 1'b0;
  logic               err_seen_c = 1'b0;

  always #5 clk = ~clk;

  max_pool_stage #(.M(4), .DW(32), .RELU(1)) dut_a (
    .clk(clk), .global_rst(rst), .ce(ce), .conv_op(conv_ab), .valid_conv(valid_ab),
    .end_conv(end_ab), .pool_op(pool_a), .valid_pool(vp_a), .end_pool(ep_a), .frame_err(er_a));

  max_pool_stage #(.M(4), .DW(32), .RELU(0)) dut_b (
    .clk(clk), .global_rst(rst), .ce(ce), .conv_op(conv_ab), .valid_conv(valid_ab),
    .end_conv(end_ab), .pool_op(pool_b), .valid_pool(vp_b), .end_pool(ep_b), .frame_err(er_b));

  max_pool_stage #(.M(MC)) dut_c (
    .clk(clk), .global_rst(rst), .ce(ce), .conv_op(conv_c), .valid_conv(valid_c),
    .end_conv(end_c), .pool_op(pool_c), .valid_pool(vp_c), .end_pool(ep_c), .frame_err(er_c));

  // Record every pulse of the M=2 instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (vp_c) begin
      cnt_c++;
      last_c = pool_c;
      end_seen_c = end_seen_c | ep_c;
    end
    if (er_c) err_seen_c = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  // Window outputs of a 4x4 frame appear after these pixel indices.
  function automatic int slot_of(input int i);
    case (i)
      5:       return 0;
      7:       return 1;
      13:      return 2;
      15:      return 3;
      default: return -1;
    endcase
  endfunction

  // Drive one pixel to the M=4 pair. On the next negedge, check the result of
  // that pixel.
  task automatic px(input int x, input logic e, input logic ev, input int ea, input int eb,
                    input logic ee, input logic eerr);
    conv_ab  = x;
    valid_ab = 1'b1;
    end_ab   = e;
    @(negedge clk);
    valid_ab = 1'b0;
    end_ab   = 1'b0;
    check("valid_a", 64'(vp_a), 64'(ev));
    check("valid_b", 64'(vp_b), 64'(ev));
    if (ev) begin
      check("pool_a", 64'(pool_a), 64'(ea));
      check("pool_b", 64'(pool_b), 64'(eb));
    end
    check("end_a", 64'(ep_a), 64'(ee));
    check("end_b", 64'(ep_b), 64'(ee));
    check("err_a", 64'(er_a), 64'(eerr));
  endtask

  // Full 4x4 frame with pixel values base + step*i, and end_conv on pixel 15.
  task automatic frame4(input int base, input int step, input quad_t ea, input quad_t eb);
    for (int i = 0; i < 16; i++) begin
      int s;
      s = slot_of(i);
      px(base + step * i, i == 15, s >= 0, (s >= 0) ? ea[s] : 0, (s >= 0) ? eb[s] : 0,
         i == 15, 1'b0);
    end
  endtask

  initial begin
    quad_t qa, qb;
    int    pix_c [4];

    repeat (2) @(negedge clk);
    check("rst_pool", 64'(pool_a), 64'(0));
    check("rst_valid", 64'(vp_a), 64'(0));
    check("rst_end", 64'(ep_a), 64'(0));
    check("rst_err", 64'(er_a), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Ascending frame 0..15.
    qa = '{5, 7, 13, 15};
    frame4(0, 1, qa, qa);
    @(negedge clk);

    // Negative frame -(i+1). With ReLU the results are all zero; without it they pass through.
    qa = '{0, 0, 0, 0};
    qb = '{-1, -3, -9, -11};
    frame4(-1, -1, qa, qb);

    // Early end_conv on pixel 9: error strobe and no window output for it.
    for (int i = 0; i < 10; i++) begin
      int s;
      s = slot_of(i);
      px(i, i == 9, s >= 0, i, i, 1'b0, i == 9);
    end
    qa = '{105, 107, 113, 115};
    frame4(100, 1, qa, qa);

    // Mid-frame reset after pixel 6.
    for (int i = 0; i < 7; i++) begin
      int s;
      s = slot_of(i);
      px(i, 1'b0, s >= 0, i, i, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_pool_a", 64'(pool_a), 64'(0));
    check("mrst_pool_b", 64'(pool_b), 64'(0));
    check("mrst_valid", 64'(vp_a), 64'(0));
    check("mrst_end", 64'(ep_a), 64'(0));
    check("mrst_err", 64'(er_a), 64'(0));
    qa = '{5, 7, 13, 15};
    frame4(0, 1, qa, qa);

    // Two back-to-back frames with no gap between them.
    frame4(0, 1, qa, qa);
    qa = '{21, 23, 29, 31};
    frame4(16, 1, qa, qa);

    // M=2 instance: convolver-sized stream with random gaps and a 3-cycle ce stall.
    pix_c = '{17, -4, 42, 9};
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (k == 2) begin
        // Offer a larger pixel while ce is low. It must be ignored.
        ce = 1'b0;
        conv_c = 99;
        valid_c = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("stall_valid_c", 64'(vp_c), 64'(0));
        end
        ce = 1'b1;
        valid_c = 1'b0;
      end
      conv_c  = pix_c[k];
      valid_c = 1'b1;
      end_c   = (k == 3);
      @(negedge clk);
      valid_c = 1'b0;
      end_c   = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("c_count", 64'(cnt_c), 64'(1));
    check("c_value", 64'(last_c), 64'(42));
    check("c_end", 64'(end_seen_c), 64'(1));
    check("c_err", 64'(err_seen_c), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max_pool_stage.md
Name: max_pool_stage

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the convolver; consumes its raster-ordered output stream (conv_op / valid_conv / end_conv).
- Optional ReLU on each pooled result.
- Emits one pooled value per 2x2 window, plus an end-of-frame strobe, to the next layer.
- Holds the top row of each window pair in an on-chip line buffer of M/2 partial maxima; no external memory.

Parameters:
- M, 2, conv feature-map width = height, equal to (n-k)/s+1 of the feeding convolver; must be even and >= 2.
- DW, 32, data width of conv_op and pool_op; signed two's complement.
- RELU, 1, 1 clamps negative pooled results to 0; 0 passes them unchanged.

Ports:
- clk  in  1  single clock, rising edge
- global_rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when low, all state holds
- conv_op  in  DW  convolver output pixel, signed
- valid_conv  in  1  conv_op valid this cycle (sampled only when ce=1)
- end_conv  in  1  marks the last valid pixel of a conv frame
- pool_op  out  DW  pooled (and optionally ReLU'd) result
- valid_pool  out  1  one-cycle strobe: pool_op is valid
- end_pool  out  1  one-cycle strobe, coincident with valid_pool of the last window of a frame
- frame_err  out  1  one-cycle strobe: end_conv arrived at a position other than (M-1, M-1)

Behaviour:
- Reset (global_rst=1 at a clk edge) wins over ce.
  - Clears the column counter col (0..M-1), the row counter row (0..M-1), hmax, and all line-buffer entries.
  - Clears pool_op=0, valid_pool=0, end_pool=0, frame_err=0.
  - Applies mid-frame as well: the next accepted pixel is treated as (0,0).
- ce=0: counters, buffers and pool_op hold; valid_pool, end_pool and frame_err are driven 0.
- An accepted pixel is a cycle with ce=1 and valid_conv=1. Non-valid cycles between pixels are allowed and change nothing.
- All comparisons are signed DW-bit; ties select either operand (values are equal).
- Per accepted pixel x at (row, col):
  - col even: hmax <= x.
  - col odd: h = max(hmax, x).
    - row even: linebuf[col/2] <= h.
    - row odd: pooled = max(linebuf[col/2], h); pool_op <= (RELU && pooled<0) ? 0 : pooled; valid_pool <= 1.
- Latency: valid_pool rises on the clk edge after the accepted cycle carrying the bottom-right pixel of the window (1 cycle).
- Counters:
  - col increments per accepted pixel and wraps at M-1 to 0, which increments row.
  - row wraps at M-1 to 0.
- Frame end:
  - end_conv with an accepted pixel at (M-1, M-1): end_pool <= 1 together with that window's valid_pool; counters wrap to (0,0).
  - end_conv at any other position: frame_err <= 1, that pixel is discarded (no output), counters and hmax reset to (0,0). The line buffer is not cleared, because every entry is rewritten before its next use.
  - Reaching (M-1, M-1) without end_conv: behaves as a normal wrap, end_pool=0, frame_err=0.
- end_conv with valid_conv=0 is ignored.
- Outputs per frame: (M/2)^2 valid_pool strobes, in raster order of windows.

Decomposition:
- Shared package (cnn_pkg), used by the convolver, this block and later stages:
  - signed max helper function
  - DW default constant
  - feature-map size function fm_size(n,k,s) = (n-k)/s+1
- One natural sub-module: pool_line_buffer, an M/2-entry x DW register array with a single write port and a single combinational read port indexed by col/2.
- Counters, hmax and output registers stay in max_pool_stage.

Test Plan:
- M=4, RELU=1, back-to-back pixels 0..15 raster, end_conv on pixel 15 -> valid_pool pulses carrying 5, 7, 13, 15, each 1 cycle after pixels 5, 7, 13, 15; end_pool only with 15; frame_err never.
- M=4, RELU=0, pixels -(i+1) for i=0..15 -> outputs -1, -3, -9, -11. Same stream with RELU=1 -> 0, 0, 0, 0.
- M=2 default, driven by a convolver (n=6, k=5, s=1) stream with random idle gaps on valid_conv and ce toggled low for 3 cycles mid-window -> exactly one valid_pool, equal to the max of the 4 conv outputs; nothing emitted while ce=0.
- M=4, end_conv asserted on pixel 9 -> frame_err pulse, no valid_pool for pixel 9. Next frame 100..115 -> outputs 105, 107, 113, 115.
- M=4, global_rst for 1 cycle after pixel 6 (with ce=1) -> all outputs 0. A following full frame 0..15 -> 5, 7, 13, 15 with no stale data.
- Two consecutive frames with no gap, second frame 16..31 -> 8 outputs, the second four being 21, 23, 29, 31; end_pool twice.
